promedio_uart_tx: RTL and testbench
===================================

# promedio_uart_tx

Serial transmitter for averaged temperature-sensor readings. It captures each N-bit average when the averager pulses `sum_redy`, then shifts the value out as an 8-N-1-style UART frame with an N-bit data field on a single output pin. A one-entry holding register absorbs one result that arrives while a frame is in flight, and a sticky flag reports any further loss.

## Interface
Parameters:
- `N`, 8: width of the data field; must equal the averager's output width.
- `CLKS_PER_BIT`, 16: clock cycles per serial bit, minimum 2. The bit-counter width is derived from it.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high.
- `en` input 1: block enable. Low means a synchronous clear of all state except `reset`-only behaviour.
- `data_in` input N: averaged value; connects to the averager's `out`.
- `data_valid` input 1: one-cycle strobe; connects to the averager's `sum_redy`.
- `tx` output 1: serial line, idle high.
- `busy` output 1: high while a frame is being transmitted.
- `overrun` output 1: sticky; set when a pending value is overwritten.

## Operation
- Reset value of every output, and the value while `en`=0: `tx`=1, `busy`=0, `overrun`=0. In the same conditions the FSM goes to IDLE and the holding register is emptied.
- FSM states and transitions:
  - IDLE: waits for a capture.
  - START: drives `tx`=0 for CLKS_PER_BIT cycles.
  - DATA: sends N bits, LSB first, each held for CLKS_PER_BIT cycles.
  - STOP: drives `tx`=1 for CLKS_PER_BIT cycles.
  - IDLE→START when `data_valid`=1 is sampled, or when the holding register is full. `data_in` is latched into the shift register in that same edge.
  - START→DATA, DATA→DATA for each next bit, DATA→STOP after bit N-1, and STOP→IDLE/START each happen when the baud counter reaches CLKS_PER_BIT-1.
- Holding register:
  - `data_valid` while not in IDLE: the value goes into the holding register if it is empty.
  - If the holding register is full, the new value overwrites it and `overrun` is set to 1 and stays set until `reset` or `en`=0.
- End of STOP:
  - Holding register full: go directly to START, move the held value into the shift register, and empty the holding register.
  - Holding register empty: go to IDLE.
- `data_valid` on the same edge as the end of STOP: that value goes straight into the shift register and the next frame starts. It is not held and does not count as an overrun. If the holding register is also full at that edge, the held value is sent first, the new value goes into the holding register, and `overrun` is not set.
- `tx` is driven from a register. `busy` = (state ≠ IDLE), also registered.
- `data_in` is sampled only on a `data_valid` edge; it may change freely at any other time.

## Timing
- Capture latency: `data_valid` sampled at edge k gives `tx`=0 and `busy`=1 from edge k (registered, visible in cycle k+1).
- Frame length: (N+2)·CLKS_PER_BIT cycles. With defaults that is 160 cycles.
  - Start bit occupies cycles [k+1, k+16].
  - Data bit i occupies [k+17+16i, k+32+16i].
  - Stop bit occupies [k+145, k+160].
- Back-to-back frames: the next start bit begins in the cycle immediately after the last stop-bit cycle, with no idle gap.
- Mid-frame `reset` or `en`=0: takes effect at the next edge. `tx` returns to 1 and the partial frame is abandoned.
- After `en` rises again, the first `data_valid` follows the normal capture latency.

## Test plan
- Single frame, defaults: `data_in`=8'hA5 with a `data_valid` pulse → `tx` shows 0, then 1,0,1,0,0,1,0,1, then 1, each bit lasting exactly 16 cycles. `busy` is high for 160 cycles, and `overrun`=0.
- Queued frame: 8'h3C, then 8'hC3 pulsed 40 cycles later → two frames back-to-back with no idle gap. `busy` stays high for 320 cycles and `overrun`=0.
- Overrun: 8'h01, 8'h02 and 8'h03 pulsed at cycles 0, 20 and 40 → frames 8'h01 then 8'h03 are sent, and `overrun`=1 from cycle 41 until reset.
- Boundary edge: second pulse (8'hFF) coincides with the last stop-bit edge of frame 8'h00 → the 8'hFF frame starts on the next cycle and `overrun`=0.
- Mid-frame abort: `reset`=1 for 1 cycle at cycle 70 of frame 8'h55 → at the next edge `tx`=1, `busy`=0 and `overrun`=0. A later 8'h0F pulse produces a clean full frame.
- Parameter sweep: N=4, CLKS_PER_BIT=3, `data_in`=4'h9 → frame of 18 cycles with bits 0,1,0,0,1,1, each lasting 3 cycles.

Source files
------------

// File: rtl/promedio_uart_tx.sv
// UART-style serial transmitter for averaged sensor readings: start bit, N data bits LSB first, stop bit.
// A one-entry holding register absorbs a result arriving mid-frame; further losses set a sticky overrun flag.
module promedio_uart_tx #(
    parameter int N            = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [N-1:0] data_in,
    input  logic         data_valid,
    output logic         tx,
    output logic         busy,
    output logic         overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [BW-1:0]  bit_idx;
    logic [N-1:0]   shreg;
    logic [N-1:0]   hold;
    logic           hold_full;
    logic           baud_done;
    logic           launch;

    // A frame launches from IDLE, or chains directly out of the last stop-bit cycle.
    always_comb begin
        baud_done = (cnt == CW'(CLKS_PER_BIT - 1));
        launch    = 1'b0;
        if (state == IDLE || (state == STOP && baud_done))
            launch = data_valid || hold_full;
    end

    always_ff @(posedge clk) begin
        if (reset || !en) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            tx        <= 1'b1;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else if (launch) begin
            state <= START;
            cnt   <= '0;
            tx    <= 1'b0;
            busy  <= 1'b1;
            // A held value goes out first; a coincident new value takes its place without overrun.
            if (hold_full) begin
                shreg     <= hold;
                hold_full <= data_valid;
                if (data_valid)
                    hold <= data_in;
            end else begin
                shreg <= data_in;
            end
        end else begin
            if (data_valid && state != IDLE) begin
                hold      <= data_in;
                hold_full <= 1'b1;
                if (hold_full)
                    overrun <= 1'b1;
            end
            case (state)
                START: begin
                    if (baud_done) begin
                        cnt     <= '0;
                        state   <= DATA;
                        bit_idx <= '0;
                        tx      <= shreg[0];
                        shreg   <= shreg >> 1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        cnt <= '0;
                        if (bit_idx == BW'(N - 1)) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + BW'(1);
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        cnt   <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_promedio_uart_tx.sv
// Directed bench for promedio_uart_tx: table of single frames plus hand-written queue, overrun,
// boundary, abort and parameter-sweep sequences, every expected line pattern written out by hand.
module tb_promedio_uart_tx;

    logic       clk = 1'b0;
    logic       reset, en, dv, dv2;
    logic [7:0] din;
    logic [3:0] din2;
    logic       tx, busy, ov, tx2, busy2, ov2;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    promedio_uart_tx #(.N(8), .CLKS_PER_BIT(16)) dut (
        .clk(clk), .reset(reset), .en(en), .data_in(din), .data_valid(dv),
        .tx(tx), .busy(busy), .overrun(ov)
    );

    promedio_uart_tx #(.N(4), .CLKS_PER_BIT(3)) dut4 (
        .clk(clk), .reset(reset), .en(en), .data_in(din2), .data_valid(dv2),
        .tx(tx2), .busy(busy2), .overrun(ov2)
    );

    // Expected line, transmit order from bit 0: start(0), data LSB first, stop(1).
    typedef struct {
        logic [7:0] data;
        logic [9:0] line;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input int idx, input logic got, input logic want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s [%0d]: got %b want %b", nm, idx, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // data_in is scrambled after the strobe: only the strobed value may be used.
    task automatic pulse(input logic [7:0] v);
        din = v;
        dv  = 1'b1;
        tick();
        dv  = 1'b0;
        din = 8'($urandom);
    endtask

    task automatic idle_chk(input string nm, input logic ov_want);
        chk({nm, ".tx"}, 0, tx, 1'b1);
        chk({nm, ".busy"}, 0, busy, 1'b0);
        chk({nm, ".ovr"}, 0, ov, ov_want);
    endtask

    // Called in the first cycle of a frame; returns in the cycle after its last stop-bit cycle.
    task automatic run_frame(input string nm, input logic [9:0] line,
                             input int p1_at, input logic [7:0] p1_val,
                             input int p2_at, input logic [7:0] p2_val, input int ov_on);
        for (int i = 0; i < 160; i++) begin
            chk({nm, ".tx"}, i, tx, line[i / 16]);
            chk({nm, ".busy"}, i, busy, 1'b1);
            chk({nm, ".ovr"}, i, ov, (i >= ov_on));
            if (i == p1_at)
                pulse(p1_val);
            else if (i == p2_at)
                pulse(p2_val);
            else
                tick();
        end
    endtask

    initial begin
        logic [5:0] line4;

        vecs[0] = '{8'hA5, 10'b1_10100101_0};
        vecs[1] = '{8'h00, 10'b1_00000000_0};
        vecs[2] = '{8'hFF, 10'b1_11111111_0};
        vecs[3] = '{8'h55, 10'b1_01010101_0};
        vecs[4] = '{8'h0F, 10'b1_00001111_0};
        vecs[5] = '{8'h3C, 10'b1_00111100_0};

        reset = 1'b1; en = 1'b1; dv = 1'b0; dv2 = 1'b0; din = '0; din2 = '0;
        tick();
        tick();
        idle_chk("reset", 1'b0);
        chk("reset4.tx", 0, tx2, 1'b1);
        chk("reset4.busy", 0, busy2, 1'b0);
        chk("reset4.ovr", 0, ov2, 1'b0);
        reset = 1'b0;
        tick();

        for (int v = 0; v < 6; v++) begin
            pulse(vecs[v].data);
            run_frame($sformatf("vec%0d", v), vecs[v].line, -1, 8'h00, -1, 8'h00, 1000);
            idle_chk($sformatf("vec%0d_end", v), 1'b0);
            repeat (3) tick();
        end

        // Queued frame: second value held, chained with no idle gap.
        pulse(8'h3C);
        run_frame("q1", 10'b1_00111100_0, 39, 8'hC3, -1, 8'h00, 1000);
        run_frame("q2", 10'b1_11000011_0, -1, 8'h00, -1, 8'h00, 1000);
        idle_chk("q_end", 1'b0);
        repeat (3) tick();

        // Overrun: 0x02 held then overwritten by 0x03.
        pulse(8'h01);
        run_frame("o1", 10'b1_00000001_0, 19, 8'h02, 39, 8'h03, 40);
        run_frame("o2", 10'b1_00000011_0, -1, 8'h00, -1, 8'h00, 0);
        idle_chk("o_end", 1'b1);
        repeat (5) tick();
        idle_chk("o_sticky", 1'b1);
        en = 1'b0;
        tick();
        idle_chk("o_en_clr", 1'b0);
        en = 1'b1;
        tick();

        // Second strobe on the final stop-bit edge starts the next frame immediately.
        pulse(8'h00);
        run_frame("b1", 10'b1_00000000_0, 159, 8'hFF, -1, 8'h00, 1000);
        run_frame("b2", 10'b1_11111111_0, -1, 8'h00, -1, 8'h00, 1000);
        idle_chk("b_end", 1'b0);
        repeat (3) tick();

        // Mid-frame reset abandons the frame.
        pulse(8'h55);
        repeat (69) tick();
        chk("abort_pre.busy", 0, busy, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle_chk("abort", 1'b0);
        repeat (4) tick();
        pulse(8'h0F);
        run_frame("abort_f", 10'b1_00001111_0, -1, 8'h00, -1, 8'h00, 1000);
        idle_chk("abort_end", 1'b0);
        repeat (3) tick();

        // en low while a value is held: nothing must be sent afterwards.
        pulse(8'hA5);
        repeat (20) tick();
        pulse(8'h5A);
        repeat (10) tick();
        en = 1'b0;
        tick();
        en = 1'b1;
        for (int i = 0; i < 200; i += 20) begin
            idle_chk($sformatf("en_hold_%0d", i), 1'b0);
            repeat (20) tick();
        end

        // N=4, CLKS_PER_BIT=3, 4'h9: line 0,1,0,0,1,1.
        line4 = 6'b110010;
        din2  = 4'h9;
        dv2   = 1'b1;
        tick();
        dv2   = 1'b0;
        din2  = 4'h0;
        for (int i = 0; i < 18; i++) begin
            chk("p4.tx", i, tx2, line4[i / 3]);
            chk("p4.busy", i, busy2, 1'b1);
            tick();
        end
        chk("p4_end.tx", 0, tx2, 1'b1);
        chk("p4_end.busy", 0, busy2, 1'b0);
        chk("p4_end.ovr", 0, ov2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
